// File: rtl/psum_axis_tx.sv
// psum_axis_tx: buffers MAC-array psum vectors in a small FIFO and streams each one out as AXI-Stream beats.
// Build macro PSUM_TX_STRB_EN: when defined, TSTRB on the final beat marks only the bytes that hold psum bits.
module psum_axis_tx #(
  parameter int MAC_NUM              = 256,
  parameter int PSUM_WIDTH           = 5,
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int PSUM_FIFO_DEPTH      = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [PSUM_WIDTH*MAC_NUM-1:0]       psum_in,
  input  logic                                psum_valid,
  output logic                                psum_ready,
  input  logic [15:0]                         frame_len,
  output logic                                M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
  output logic                                M_AXIS_TLAST,
  input  logic                                M_AXIS_TREADY,
  output logic                                tx_busy,
  output logic                                frame_done,
  output logic                                psum_overflow
);

  localparam int VEC_W = PSUM_WIDTH * MAC_NUM;
  localparam int W     = C_M_AXIS_TDATA_WIDTH;
  localparam int SW    = W / 8;
  localparam int BEATS = (VEC_W + W - 1) / W;
  localparam int SR_W  = BEATS * W;
  localparam int BC_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int AW    = $clog2(PSUM_FIFO_DEPTH);
  localparam logic [BC_W-1:0] LAST_BEAT     = BC_W'(BEATS - 1);
  localparam logic [AW:0]     FIFO_FULL_CNT = (AW + 1)'(PSUM_FIFO_DEPTH);

  typedef enum logic [0:0] {TX_IDLE, TX_SEND} tx_state_e;

  logic [VEC_W-1:0] mem [PSUM_FIFO_DEPTH];
  logic [VEC_W-1:0] rd_data;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             full_q, empty_q, overflow_q;
  logic             push, pop;

  tx_state_e        state_q;
  logic [BC_W-1:0]  beat_cnt_q;
  logic [15:0]      vec_cnt_q, len_q;
  logic [SR_W-1:0]  sr_q;
  logic             frame_done_q;

  logic             tvalid, hs, last_beat, end_vec, vec_wrap;
  logic [15:0]      vec_cnt_adv, pop_vcnt;
  logic [SW-1:0]    strb_beat;

  assign psum_ready = ~full_q;
  assign push       = psum_valid & ~full_q;
  assign rd_data    = mem[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + 1'b1;
    else if (!push && pop)
      count_d = count_q - 1'b1;
  end

  // Full/empty are registered so psum_ready never depends on the pop decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push)
        wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)
        rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == FIFO_FULL_CNT);
      empty_q <= (count_d == '0);
      if (psum_valid && full_q)
        overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_q] <= psum_in;
  end

  assign tvalid      = (state_q == TX_SEND);
  assign hs          = tvalid & M_AXIS_TREADY;
  assign last_beat   = (beat_cnt_q == LAST_BEAT);
  assign end_vec     = hs & last_beat;
  assign vec_wrap    = (vec_cnt_q == len_q - 16'd1);
  assign vec_cnt_adv = vec_wrap ? 16'd0 : vec_cnt_q + 16'd1;
  // A pop at the end of a vector refills sr in the same cycle, so frames stream without bubbles.
  assign pop         = ~empty_q & ((state_q == TX_IDLE) | end_vec);
  assign pop_vcnt    = (state_q == TX_IDLE) ? vec_cnt_q : vec_cnt_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= TX_IDLE;
      beat_cnt_q   <= '0;
      vec_cnt_q    <= '0;
      len_q        <= 16'd1;
      sr_q         <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= end_vec & vec_wrap;
      if (end_vec)
        vec_cnt_q <= vec_cnt_adv;
      if (pop && pop_vcnt == 16'd0)
        len_q <= (frame_len == 16'd0) ? 16'd1 : frame_len;
      case (state_q)
        TX_IDLE: begin
          if (pop) begin
            sr_q       <= SR_W'(rd_data);
            beat_cnt_q <= '0;
            state_q    <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (hs) begin
            if (!last_beat) begin
              beat_cnt_q <= beat_cnt_q + 1'b1;
              sr_q       <= sr_q >> W;
            end else if (pop) begin
              sr_q       <= SR_W'(rd_data);
              beat_cnt_q <= '0;
            end else begin
              sr_q       <= '0;
              beat_cnt_q <= '0;
              state_q    <= TX_IDLE;
            end
          end
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

`ifdef PSUM_TX_STRB_EN
  localparam int LAST_BITS = VEC_W - (BEATS - 1) * W;
  logic [SW-1:0] last_strb;
  for (genvar gi = 0; gi < SW; gi++) begin : g_last_strb
    assign last_strb[gi] = (gi * 8 < LAST_BITS);
  end
  assign strb_beat = last_beat ? last_strb : '1;
`else
  assign strb_beat = '1;
`endif

  assign M_AXIS_TVALID = tvalid;
  assign M_AXIS_TDATA  = tvalid ? sr_q[W-1:0] : '0;
  assign M_AXIS_TSTRB  = tvalid ? strb_beat : '0;
  assign M_AXIS_TLAST  = tvalid & last_beat & vec_wrap;
  assign tx_busy       = ~empty_q | tvalid;
  assign frame_done    = frame_done_q;
  assign psum_overflow = overflow_q;

endmodule

// File: tb/tb_psum_axis_tx.sv
// Self-checking bench for psum_axis_tx: default-size instance with a beat scoreboard plus a MAC_NUM=4 instance.
module tb_psum_axis_tx;
  localparam int VEC_W = 1280;
  localparam int W     = 32;
  localparam int BEATS = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [VEC_W-1:0] psum_in;
  logic             psum_valid, psum_ready;
  logic [15:0]      frame_len;
  logic             tvalid, tlast, tready, tx_busy, frame_done, psum_overflow;
  logic [31:0]      tdata;
  logic [3:0]       tstrb;

  logic [19:0]      s_psum_in;
  logic             s_psum_valid, s_psum_ready;
  logic [15:0]      s_frame_len;
  logic             s_tvalid, s_tlast, s_tready, s_tx_busy, s_frame_done, s_overflow;
  logic [31:0]      s_tdata;
  logic [3:0]       s_tstrb;

  psum_axis_tx dut (
    .clk(clk), .rst_n(rst_n), .psum_in(psum_in), .psum_valid(psum_valid), .psum_ready(psum_ready),
    .frame_len(frame_len), .M_AXIS_TVALID(tvalid), .M_AXIS_TDATA(tdata), .M_AXIS_TSTRB(tstrb),
    .M_AXIS_TLAST(tlast), .M_AXIS_TREADY(tready), .tx_busy(tx_busy), .frame_done(frame_done),
    .psum_overflow(psum_overflow)
  );

  psum_axis_tx #(.MAC_NUM(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .psum_in(s_psum_in), .psum_valid(s_psum_valid), .psum_ready(s_psum_ready),
    .frame_len(s_frame_len), .M_AXIS_TVALID(s_tvalid), .M_AXIS_TDATA(s_tdata), .M_AXIS_TSTRB(s_tstrb),
    .M_AXIS_TLAST(s_tlast), .M_AXIS_TREADY(s_tready), .tx_busy(s_tx_busy), .frame_done(s_frame_done),
    .psum_overflow(s_overflow)
  );

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } beat_t;

  beat_t exp_q[$];
  beat_t obs_q[$];
  int    obs_cyc[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    fd_cnt = 0;
  int    m_vcnt = 0;
  int    m_len = 1;

  // Reference model: split a vector into beats and mark TLAST from the frame position.
  task automatic push_exp(input logic [VEC_W-1:0] vec, input int flen);
    beat_t b;
    if (m_vcnt == 0) m_len = (flen == 0) ? 1 : flen;
    for (int k = 0; k < BEATS; k++) begin
      b.data = vec[k*W +: W];
      b.last = (k == BEATS - 1) && (m_vcnt == m_len - 1);
      exp_q.push_back(b);
    end
    m_vcnt = (m_vcnt == m_len - 1) ? 0 : m_vcnt + 1;
  endtask

  // Record the handshake of the current cycle, then advance to the next falling edge.
  task automatic step();
    beat_t b;
    if (tvalid && tready) begin
      b.last = tlast;
      b.data = tdata;
      obs_q.push_back(b);
      obs_cyc.push_back(cyc);
    end
    if (frame_done) fd_cnt++;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drive_push(input logic [VEC_W-1:0] v);
    psum_in    = v;
    psum_valid = 1'b1;
    step();
    psum_valid = 1'b0;
  endtask

  task automatic clear_obs();
    obs_q.delete();
    obs_cyc.delete();
    fd_cnt = 0;
  endtask

  function automatic logic [VEC_W-1:0] rand_vec();
    logic [VEC_W-1:0] v;
    for (int j = 0; j < VEC_W / 32; j++) v[j*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic test_reset();
    total++;
    if ({psum_ready, tvalid, tlast, tx_busy, frame_done, psum_overflow} !== 6'b100000) begin
      bad++;
      $display("FAIL reset_flags got=%b want=100000",
               {psum_ready, tvalid, tlast, tx_busy, frame_done, psum_overflow});
    end
    total++;
    if (tdata !== 32'h0 || tstrb !== 4'h0) begin
      bad++; $display("FAIL reset_data got tdata=%h tstrb=%h want 0/0", tdata, tstrb);
    end
    total++;
    if ({s_psum_ready, s_tvalid, s_tx_busy, s_overflow} !== 4'b1000) begin
      bad++; $display("FAIL reset_small got=%b want=1000", {s_psum_ready, s_tvalid, s_tx_busy, s_overflow});
    end
    rst_n = 1'b1;
    step();
    $display("test_reset done");
  endtask

  task automatic test_single();
    logic [VEC_W-1:0] v;
    beat_t o, e;
    for (int i = 0; i < 256; i++) v[i*5 +: 5] = 5'(i % 32);
    frame_len = 16'd1; tready = 1'b1;
    clear_obs();
    push_exp(v, 1);
    drive_push(v);
    total++;
    if (tvalid !== 1'b0) begin bad++; $display("FAIL single_lat1 got tvalid=%b want=0", tvalid); end
    step();
    total++;
    if (tvalid !== 1'b1) begin bad++; $display("FAIL single_lat2 got tvalid=%b want=1", tvalid); end
    total++;
    if (tdata !== 32'h8A418820) begin bad++; $display("FAIL single_beat0 got=%h want=8a418820", tdata); end
    total++;
    if (tx_busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b want=1", tx_busy); end
    for (int t = 0; t < 100 && obs_q.size() < 40; t++) step();
    for (int t = 0; t < 3; t++) step();
    total++;
    if (obs_q.size() != 40) begin bad++; $display("FAIL single_count got=%0d want=40", obs_q.size()); end
    total++;
    if (obs_cyc.size() > 0 && obs_cyc[obs_cyc.size()-1] - obs_cyc[0] != obs_cyc.size() - 1) begin
      bad++; $display("FAIL single_gap got span=%0d want=%0d", obs_cyc[obs_cyc.size()-1] - obs_cyc[0], obs_cyc.size() - 1);
    end
    total++;
    if (fd_cnt != 1) begin bad++; $display("FAIL single_frame_done got=%0d want=1", fd_cnt); end
    total++;
    if (tx_busy !== 1'b0) begin bad++; $display("FAIL single_idle_busy got=%b want=0", tx_busy); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL single_beat got=%h want=%h", o, e); end
    end
    exp_q.delete();
    $display("test_single done");
  endtask

  task automatic test_back_to_back();
    logic [VEC_W-1:0] v;
    beat_t o, e;
    frame_len = 16'd3; tready = 1'b1;
    clear_obs();
    for (int n = 0; n < 3; n++) begin
      v = rand_vec();
      push_exp(v, 3);
      drive_push(v);
    end
    frame_len = 16'd7;
    for (int t = 0; t < 300 && obs_q.size() < 120; t++) step();
    for (int t = 0; t < 3; t++) step();
    total++;
    if (obs_q.size() != 120) begin bad++; $display("FAIL b2b_count got=%0d want=120", obs_q.size()); end
    total++;
    if (obs_cyc.size() > 0 && obs_cyc[obs_cyc.size()-1] - obs_cyc[0] != 119) begin
      bad++; $display("FAIL b2b_gap got span=%0d want=119", obs_cyc[obs_cyc.size()-1] - obs_cyc[0]);
    end
    total++;
    if (fd_cnt != 1) begin bad++; $display("FAIL b2b_frame_done got=%0d want=1", fd_cnt); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL b2b_beat got=%h want=%h", o, e); end
    end
    exp_q.delete();
    $display("test_back_to_back done");
  endtask

  task automatic test_stall();
    logic [VEC_W-1:0] v;
    logic [3:0] pat;
    logic prev_stall, prev_last;
    logic [31:0] prev_data;
    beat_t o, e;
    pat = 4'b1001;
    prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;
    frame_len = 16'd0; tready = 1'b1;
    clear_obs();
    v = rand_vec();
    push_exp(v, 0);
    drive_push(v);
    for (int t = 0; t < 400 && obs_q.size() < 40; t++) begin
      tready = pat[t % 4];
      if (prev_stall) begin
        total++;
        if ({tvalid, tlast, tdata} !== {1'b1, prev_last, prev_data}) begin
          bad++; $display("FAIL stall_hold got=%b/%b/%h want=1/%b/%h", tvalid, tlast, tdata, prev_last, prev_data);
        end
      end
      prev_stall = tvalid && !tready;
      prev_last  = tlast;
      prev_data  = tdata;
      step();
    end
    tready = 1'b1;
    for (int t = 0; t < 3; t++) step();
    total++;
    if (obs_q.size() != 40) begin bad++; $display("FAIL stall_count got=%0d want=40", obs_q.size()); end
    total++;
    if (fd_cnt != 1) begin bad++; $display("FAIL stall_frame_done got=%0d want=1", fd_cnt); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL stall_beat got=%h want=%h", o, e); end
    end
    exp_q.delete();
    $display("test_stall done");
  endtask

  task automatic test_overflow();
    logic [VEC_W-1:0] v;
    logic exp_ready;
    beat_t o, e;
    frame_len = 16'd1; tready = 1'b0;
    clear_obs();
    // First vector moves into the shift register, so five are accepted before the FIFO fills.
    for (int k = 0; k < 6; k++) begin
      v = rand_vec();
      psum_in = v; psum_valid = 1'b1;
      exp_ready = (k < 5);
      total++;
      if (psum_ready !== exp_ready) begin
        bad++; $display("FAIL ovf_ready push=%0d got=%b want=%b", k, psum_ready, exp_ready);
      end
      if (exp_ready) push_exp(v, 1);
      step();
    end
    psum_valid = 1'b0;
    total++;
    if ({psum_overflow, psum_ready} !== 2'b10) begin
      bad++; $display("FAIL ovf_flag got ovf/ready=%b want=10", {psum_overflow, psum_ready});
    end
    tready = 1'b1;
    for (int t = 0; t < 500 && obs_q.size() < 200; t++) step();
    for (int t = 0; t < 3; t++) step();
    total++;
    if (obs_q.size() != 200) begin bad++; $display("FAIL ovf_count got=%0d want=200", obs_q.size()); end
    total++;
    if (fd_cnt != 5) begin bad++; $display("FAIL ovf_frame_done got=%0d want=5", fd_cnt); end
    total++;
    if ({psum_overflow, psum_ready} !== 2'b11) begin
      bad++; $display("FAIL ovf_sticky got ovf/ready=%b want=11", {psum_overflow, psum_ready});
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL ovf_beat got=%h want=%h", o, e); end
    end
    exp_q.delete();
    $display("test_overflow done");
  endtask

  task automatic test_small();
    logic [3:0] exp_strb;
    int waited;
`ifdef PSUM_TX_STRB_EN
    exp_strb = 4'b0111;
`else
    exp_strb = 4'b1111;
`endif
    s_frame_len = 16'd1; s_tready = 1'b1;
    s_psum_in = 20'hABCDE; s_psum_valid = 1'b1;
    step();
    s_psum_valid = 1'b0;
    waited = 0;
    while (!s_tvalid && waited < 10) begin step(); waited++; end
    total++;
    if (s_tvalid !== 1'b1) begin bad++; $display("FAIL small_tvalid got=%b want=1", s_tvalid); end
    total++;
    if (s_tdata !== 32'h000ABCDE) begin bad++; $display("FAIL small_tdata got=%h want=000abcde", s_tdata); end
    total++;
    if (s_tlast !== 1'b1) begin bad++; $display("FAIL small_tlast got=%b want=1", s_tlast); end
    total++;
    if (s_tstrb !== exp_strb) begin bad++; $display("FAIL small_tstrb got=%b want=%b", s_tstrb, exp_strb); end
    step();
    total++;
    if ({s_frame_done, s_tvalid, s_tstrb} !== 6'b100000) begin
      bad++; $display("FAIL small_done got fd/tvalid/tstrb=%b want=100000", {s_frame_done, s_tvalid, s_tstrb});
    end
    $display("test_small done");
  endtask

  task automatic test_reset_midframe();
    logic [VEC_W-1:0] v;
    beat_t o, e;
    frame_len = 16'd3; tready = 1'b1;
    clear_obs();
    for (int n = 0; n < 3; n++) begin
      v = rand_vec();
      push_exp(v, 3);
      drive_push(v);
    end
    for (int t = 0; t < 200 && obs_q.size() < 50; t++) step();
    rst_n = 1'b0;
    #1;
    total++;
    if ({tvalid, tlast, tx_busy, psum_ready, psum_overflow} !== 5'b00010) begin
      bad++; $display("FAIL rst_async got tvalid/tlast/busy/ready/ovf=%b want=00010",
                      {tvalid, tlast, tx_busy, psum_ready, psum_overflow});
    end
    total++;
    if (tdata !== 32'h0) begin bad++; $display("FAIL rst_tdata got=%h want=0", tdata); end
    exp_q.delete();
    m_vcnt = 0; m_len = 1;
    step(); step();
    rst_n = 1'b1;
    clear_obs();
    frame_len = 16'd1;
    v = rand_vec();
    push_exp(v, 1);
    drive_push(v);
    for (int t = 0; t < 100 && obs_q.size() < 40; t++) step();
    for (int t = 0; t < 20; t++) step();
    total++;
    if (obs_q.size() != 40) begin bad++; $display("FAIL rst_count got=%0d want=40", obs_q.size()); end
    total++;
    if (fd_cnt != 1) begin bad++; $display("FAIL rst_frame_done got=%0d want=1", fd_cnt); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL rst_beat got=%h want=%h", o, e); end
    end
    exp_q.delete();
    $display("test_reset_midframe done");
  endtask

  initial begin
    rst_n = 1'b0;
    psum_in = '0; psum_valid = 1'b0; frame_len = 16'd1; tready = 1'b0;
    s_psum_in = '0; s_psum_valid = 1'b0; s_frame_len = 16'd1; s_tready = 1'b1;
    @(negedge clk); @(negedge clk); @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_overflow();
    test_small();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
